// File: rtl/imem_loader_if.sv
// Host byte link and instruction-memory write port seen by the boot loader.
// The slave modport is the loader; the master modport is the side that
// supplies bytes and observes the memory writes (host link plus memory).
interface imem_loader_if;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;

   modport slave (
      input  rx_valid,
      input  rx_data,
      output rx_ready,
      output mem_we,
      output mem_addr,
      output mem_wdata
   );

   modport master (
      output rx_valid,
      output rx_data,
      input  rx_ready,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata
   );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader. Receives a framed byte stream
// (16-bit little-endian word count, 4*N data bytes, XOR checksum byte),
// writes little-endian 32-bit words to consecutive word addresses and keeps
// the CPU held in reset until a complete, checksum-clean program is loaded.
module imem_loader #(
   parameter int ROW = 256
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start_i,
   imem_loader_if.slave  bus,
   output logic          busy_o,
   output logic          done_o,
   output logic          err_o,
   output logic          cpu_hold_o
);

   // Word index must be able to count up to ROW itself.
   localparam int          WIDX_W  = $clog2(ROW + 1);
   localparam logic [15:0] ROW_LIM = 16'(ROW);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LEN_LO = 3'd1;
   localparam logic [2:0] S_LEN_HI = 3'd2;
   localparam logic [2:0] S_DATA   = 3'd3;
   localparam logic [2:0] S_CHK    = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   logic [2:0]        state_q, state_d;
   logic [15:0]       len_q, len_d;
   logic [WIDX_W-1:0] widx_q, widx_d;
   logic [1:0]        bidx_q, bidx_d;
   logic [23:0]       word_q, word_d;     // bytes 0..2 of the word in flight
   logic [7:0]        acc_q, acc_d;
   logic              err_q, err_d;
   logic              done_q, done_d;
   logic              we_q, we_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;

   logic              rx_ready;
   logic              xfer;
   logic [15:0]       len_full;

   // Ready decodes only the registered state, so there is no path from rx_valid.
   always_comb begin
      rx_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                 (state_q == S_DATA)   || (state_q == S_CHK);
      xfer     = bus.rx_valid && rx_ready;
      len_full = {bus.rx_data, len_q[7:0]};
   end

   // Frame parser: next-state for FSM, word assembly, checksum and write port.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      widx_d  = widx_q;
      bidx_d  = bidx_q;
      word_d  = word_q;
      acc_d   = acc_q;
      err_d   = err_q;
      done_d  = done_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               state_d = S_LEN_LO;
               widx_d  = '0;
               bidx_d  = '0;
               acc_d   = '0;
               err_d   = 1'b0;
               done_d  = 1'b0;
            end
         end
         S_LEN_LO: begin
            if (xfer) begin
               len_d[7:0] = bus.rx_data;
               state_d    = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (xfer) begin
               len_d = len_full;
               if (len_full > ROW_LIM) begin
                  err_d   = 1'b1;
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else if (len_full == 16'd0) begin
                  state_d = S_CHK;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (xfer) begin
               acc_d  = acc_q ^ bus.rx_data;
               word_d = {bus.rx_data, word_q[23:8]};
               bidx_d = bidx_q + 2'd1;
               if (bidx_q == 2'd3) begin
                  // Fourth byte completes the word; it is written next cycle.
                  we_d    = 1'b1;
                  wdata_d = {bus.rx_data, word_q};
                  addr_d  = {{(32-WIDX_W-2){1'b0}}, widx_q, 2'b00};
                  widx_d  = widx_q + 1'b1;
                  if ((16'(widx_q) + 16'd1) == len_q) begin
                     state_d = S_CHK;
                  end
               end
            end
         end
         S_CHK: begin
            if (xfer) begin
               done_d  = 1'b1;
               state_d = S_DONE;
               if (bus.rx_data != acc_q) begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset discards any partial word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         widx_q  <= '0;
         bidx_q  <= '0;
         word_q  <= '0;
         acc_q   <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         widx_q  <= widx_d;
         bidx_q  <= bidx_d;
         word_q  <= word_d;
         acc_q   <= acc_d;
         err_q   <= err_d;
         done_q  <= done_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // Output decode from registered state only.
   always_comb begin
      bus.rx_ready  = rx_ready;
      bus.mem_we    = we_q;
      bus.mem_addr  = addr_q;
      bus.mem_wdata = wdata_q;
      busy_o        = rx_ready;
      done_o        = done_q;
      err_o         = err_q;
      cpu_hold_o    = !(done_q && !err_q);
   end

endmodule
